// File: rtl/ahb_split_arbiter.sv
// Purpose : three-master AHB arbiter: round-robin, locked transfers, SPLIT/RETRY, burst hold limit.
// Latency : grant registered one hclk after request; hmaster one hready edge later, hmaster_d one more.
// Backpressure: hready=0 freezes grant and the owner pipeline, except that SPLIT/RETRY forces a rearbitration.
// Ports   : hbusreq*/hlock*/htrans* per-master requests; hready/hresp muxed slave response;
//           hsplit1..4 slave split-release vectors; hgrant* one-hot grants; hmaster/hmaster_d
//           address/data-phase owner (0 = dummy); hmastlock marks a locked address phase.
module ahb_split_arbiter #(
    parameter int DEF_MASTER = 1,
    parameter int MAX_HOLD   = 16
) (
    input  logic        hclk,
    input  logic        hreset,
    input  logic        hbusreq1,
    input  logic        hbusreq2,
    input  logic        hbusreq3,
    input  logic        hlock1,
    input  logic        hlock2,
    input  logic        hlock3,
    input  logic [1:0]  htrans1,
    input  logic [1:0]  htrans2,
    input  logic [1:0]  htrans3,
    input  logic        hready,
    input  logic [1:0]  hresp,
    input  logic [15:0] hsplit1,
    input  logic [15:0] hsplit2,
    input  logic [15:0] hsplit3,
    input  logic [15:0] hsplit4,
    output logic        hgrant1,
    output logic        hgrant2,
    output logic        hgrant3,
    output logic [1:0]  hmaster,
    output logic [1:0]  hmaster_d,
    output logic        hmastlock
);

    localparam logic [1:0] DEF_IDX  = 2'(DEF_MASTER);
    localparam logic [3:1] DEF_OH   = 3'(1 << (DEF_MASTER - 1));
    localparam logic [7:0] HOLD_MAX = 8'(MAX_HOLD);

    localparam logic [1:0] T_IDLE   = 2'b00;
    localparam logic [1:0] T_NONSEQ = 2'b10;
    localparam logic [1:0] R_RETRY  = 2'b10;
    localparam logic [1:0] R_SPLIT  = 2'b11;

    logic [3:1]  grant;
    logic [3:1]  split_mask;
    logic [1:0]  rr_ptr;
    logic [7:0]  hold_cnt;

    logic [15:0] split_rel_all;
    logic        unused_split;
    logic [3:0]  req_v;
    logic [3:0]  split_set;
    logic [3:0]  eff_mask;
    logic [3:0]  elig;
    logic        split_first;
    logic        retry_first;
    logic        hold_hit;
    logic        normal_ok;
    logic        rearb;
    logic        others;
    logic [1:0]  owner_idx;
    logic [1:0]  owner_trans;
    logic        owner_req;
    logic        owner_lock;
    logic [1:0]  start_ptr;
    logic [2:0]  cand;
    logic [1:0]  pick;
    logic [1:0]  next_idx;
    logic [3:1]  next_grant;

    // Only bits [3:1] of the release vectors name real masters.
    assign split_rel_all = hsplit1 | hsplit2 | hsplit3 | hsplit4;
    assign unused_split  = ^{split_rel_all[15:4], split_rel_all[0]};

    // Vectors are indexed by master number; bit 0 is a permanent zero.
    assign req_v = {hbusreq3, hbusreq2, hbusreq1, 1'b0};

    // Only the first (hready=0) cycle of the two-cycle response acts.
    assign split_first = (hresp == R_SPLIT) && !hready;
    assign retry_first = (hresp == R_RETRY) && !hready;

    // A SPLIT excludes its master already on the edge that parks it.
    assign split_set = (split_first && hmaster_d != 2'd0) ? (4'd1 << hmaster_d) : 4'd0;
    assign eff_mask  = {split_mask, 1'b0} | split_set;
    assign elig      = req_v & ~eff_mask;
    assign others    = |(elig & ~{grant, 1'b0});
    assign hold_hit  = (hold_cnt == HOLD_MAX);

    always_comb begin
        owner_idx   = 2'd0;
        owner_trans = T_IDLE;
        owner_req   = 1'b0;
        owner_lock  = 1'b0;
        case (grant)
            3'b001: begin
                owner_idx   = 2'd1;
                owner_trans = htrans1;
                owner_req   = hbusreq1;
                owner_lock  = hlock1;
            end
            3'b010: begin
                owner_idx   = 2'd2;
                owner_trans = htrans2;
                owner_req   = hbusreq2;
                owner_lock  = hlock2;
            end
            3'b100: begin
                owner_idx   = 2'd3;
                owner_trans = htrans3;
                owner_req   = hbusreq3;
                owner_lock  = hlock3;
            end
            default: ;
        endcase
    end

    // Lock pins the owner unless the slave itself pushes it off with SPLIT/RETRY.
    assign normal_ok = (owner_idx == 2'd0) ||
                       (!owner_lock && ((owner_trans == T_IDLE) || !owner_req ||
                                        (hold_hit && owner_trans == T_NONSEQ)));
    assign rearb     = split_first || retry_first || (hready && normal_ok);

    // The retrying master becomes the round-robin reference, so it ranks last.
    assign start_ptr = (retry_first && hmaster_d != 2'd0) ? hmaster_d : rr_ptr;

    // Scan from furthest to nearest so the nearest eligible master wins.
    always_comb begin
        pick = 2'd0;
        cand = 3'd0;
        for (int k = 3; k >= 1; k--) begin
            cand = {1'b0, start_ptr} + 3'(k);
            if (cand > 3'd3) begin
                cand = cand - 3'd3;
            end
            if (elig[cand[1:0]]) begin
                pick = cand[1:0];
            end
        end
        if (pick == 2'd0 && !eff_mask[DEF_MASTER]) begin
            pick = DEF_IDX;
        end
    end

    assign next_idx = rearb ? pick : owner_idx;

    always_comb begin
        next_grant = 3'b000;
        case (next_idx)
            2'd1:    next_grant = 3'b001;
            2'd2:    next_grant = 3'b010;
            2'd3:    next_grant = 3'b100;
            default: next_grant = 3'b000;
        endcase
    end

    always_ff @(posedge hclk) begin
        if (hreset) begin
            grant      <= DEF_OH;
            split_mask <= 3'b000;
            rr_ptr     <= DEF_IDX;
            hold_cnt   <= 8'd0;
            hmaster    <= DEF_IDX;
            hmaster_d  <= 2'd0;
            hmastlock  <= 1'b0;
        end else begin
            grant      <= next_grant;
            // Set takes priority over a release of the same bit.
            split_mask <= (split_mask & ~split_rel_all[3:1]) | split_set[3:1];

            if (next_idx != owner_idx) begin
                hold_cnt <= 8'd0;
                if (next_idx != 2'd0) begin
                    rr_ptr <= next_idx;
                end
            end else if (retry_first && hmaster_d != 2'd0) begin
                rr_ptr <= hmaster_d;
            end else if (hready) begin
                if (!others) begin
                    hold_cnt <= 8'd0;
                end else if (!hold_hit) begin
                    hold_cnt <= hold_cnt + 8'd1;
                end
            end

            if (hready) begin
                hmaster   <= owner_idx;
                hmastlock <= owner_lock;
                hmaster_d <= hmaster;
            end
        end
    end

    assign hgrant1 = grant[1];
    assign hgrant2 = grant[2];
    assign hgrant3 = grant[3];

endmodule

// File: tb/tb_ahb_split_arbiter.sv
// Purpose : directed and randomized check of ahb_split_arbiter against a behavioural model.
// Latency : inputs driven 1 time unit after each rising edge; outputs sampled at the same point.
// Backpressure: hready and SPLIT/RETRY responses are driven by the bench, both directed and random.
module tb_ahb_split_arbiter;

    localparam int DEF  = 1;
    localparam int MAXH = 4;

    logic        hclk = 1'b0;
    logic        hreset;
    logic        hbusreq1, hbusreq2, hbusreq3;
    logic        hlock1, hlock2, hlock3;
    logic [1:0]  htrans1, htrans2, htrans3;
    logic        hready;
    logic [1:0]  hresp;
    logic [15:0] hsplit1, hsplit2, hsplit3, hsplit4;
    logic        hgrant1, hgrant2, hgrant3;
    logic [1:0]  hmaster, hmaster_d;
    logic        hmastlock;

    ahb_split_arbiter #(.DEF_MASTER(DEF), .MAX_HOLD(MAXH)) dut (
        .hclk(hclk), .hreset(hreset),
        .hbusreq1(hbusreq1), .hbusreq2(hbusreq2), .hbusreq3(hbusreq3),
        .hlock1(hlock1), .hlock2(hlock2), .hlock3(hlock3),
        .htrans1(htrans1), .htrans2(htrans2), .htrans3(htrans3),
        .hready(hready), .hresp(hresp),
        .hsplit1(hsplit1), .hsplit2(hsplit2), .hsplit3(hsplit3), .hsplit4(hsplit4),
        .hgrant1(hgrant1), .hgrant2(hgrant2), .hgrant3(hgrant3),
        .hmaster(hmaster), .hmaster_d(hmaster_d), .hmastlock(hmastlock)
    );

    always #5 hclk = ~hclk;

    int n_cmp = 0;
    int n_bad = 0;

    // Behavioural model: owner numbers as plain integers, 0 = nobody.
    int mg, mh, mhd, mml, mptr, mhold;
    int mmask[4];

    function automatic logic [2:0] gvec();
        return {hgrant3, hgrant2, hgrant1};
    endfunction

    function automatic logic [2:0] mvec(input int owner);
        logic [2:0] v;
        v = 3'b000;
        if (owner != 0) v[owner-1] = 1'b1;
        return v;
    endfunction

    task automatic model_step();
        int req[4], lk[4], tr[4], elig[4], nmask[4];
        int sf, rf, allow, start, pick, ng, others, c;
        logic [15:0] rv;
        if (hreset) begin
            mg = DEF; mh = DEF; mhd = 0; mml = 0; mptr = DEF; mhold = 0;
            for (int m = 0; m < 4; m++) mmask[m] = 0;
            return;
        end
        req[1] = int'(hbusreq1); req[2] = int'(hbusreq2); req[3] = int'(hbusreq3);
        lk[1]  = int'(hlock1);   lk[2]  = int'(hlock2);   lk[3]  = int'(hlock3);
        tr[1]  = int'(htrans1);  tr[2]  = int'(htrans2);  tr[3]  = int'(htrans3);
        rv = hsplit1 | hsplit2 | hsplit3 | hsplit4;
        sf = (hresp == 2'b11 && !hready) ? 1 : 0;
        rf = (hresp == 2'b10 && !hready) ? 1 : 0;
        nmask[0] = 0; elig[0] = 0;
        for (int m = 1; m <= 3; m++) begin
            nmask[m] = (sf != 0 && mhd == m) ? 1 : (rv[m] ? 0 : mmask[m]);
            elig[m]  = (req[m] != 0 && mmask[m] == 0 && !(sf != 0 && mhd == m)) ? 1 : 0;
        end
        if (sf != 0 || rf != 0)   allow = 1;
        else if (!hready)         allow = 0;
        else if (mg == 0)         allow = 1;
        else if (lk[mg] != 0)     allow = 0;
        else allow = (tr[mg] == 0 || req[mg] == 0 || (mhold == MAXH && tr[mg] == 2)) ? 1 : 0;
        start = (rf != 0 && mhd != 0) ? mhd : mptr;
        pick = 0;
        for (int k = 1; k <= 3; k++) begin
            c = (start + k - 1) % 3 + 1;
            if (pick == 0 && elig[c] != 0) pick = c;
        end
        if (pick == 0 && mmask[DEF] == 0 && !(sf != 0 && mhd == DEF)) pick = DEF;
        ng = (allow != 0) ? pick : mg;
        others = 0;
        for (int m = 1; m <= 3; m++) if (m != mg && elig[m] != 0) others = 1;
        if (ng != mg) begin
            mhold = 0;
            if (ng != 0) mptr = ng;
        end else if (rf != 0 && mhd != 0) begin
            mptr = mhd;
        end else if (hready) begin
            mhold = (others != 0) ? ((mhold < MAXH) ? mhold + 1 : MAXH) : 0;
        end
        if (hready) begin
            mml = (mg != 0) ? lk[mg] : 0;
            mhd = mh;
            mh  = mg;
        end
        mg = ng;
        mmask = nmask;
    endtask

    task automatic quiet();
        hreset = 1'b0;
        hbusreq1 = 1'b0; hbusreq2 = 1'b0; hbusreq3 = 1'b0;
        hlock1 = 1'b0; hlock2 = 1'b0; hlock3 = 1'b0;
        htrans1 = 2'b00; htrans2 = 2'b00; htrans3 = 2'b00;
        hready = 1'b1; hresp = 2'b00;
        hsplit1 = 16'h0; hsplit2 = 16'h0; hsplit3 = 16'h0; hsplit4 = 16'h0;
    endtask

    task automatic tick();
        model_step();
        @(posedge hclk);
        #1;
    endtask

    task automatic do_reset();
        quiet();
        hreset = 1'b1;
        tick();
        hreset = 1'b0;
    endtask

    task automatic set_trans(input int m, input logic [1:0] t);
        if (m == 1) htrans1 = t;
        if (m == 2) htrans2 = t;
        if (m == 3) htrans3 = t;
    endtask

    task automatic test_reset();
        do_reset();
        n_cmp++; if (gvec() !== 3'b001) begin n_bad++; $display("FAIL reset_grant: got %b want %b", gvec(), 3'b001); end
        n_cmp++; if (hmaster !== 2'd1) begin n_bad++; $display("FAIL reset_hmaster: got %0d want 1", hmaster); end
        n_cmp++; if (hmaster_d !== 2'd0) begin n_bad++; $display("FAIL reset_hmaster_d: got %0d want 0", hmaster_d); end
        n_cmp++; if (hmastlock !== 1'b0) begin n_bad++; $display("FAIL reset_hmastlock: got %0d want 0", hmastlock); end
        tick();
        n_cmp++; if (gvec() !== 3'b001) begin n_bad++; $display("FAIL default_park: got %b want %b", gvec(), 3'b001); end
        hbusreq2 = 1'b1;
        tick();
        n_cmp++; if (gvec() !== 3'b010) begin n_bad++; $display("FAIL req_to_grant: got %b want %b", gvec(), 3'b010); end
        n_cmp++; if (hmaster !== 2'd1) begin n_bad++; $display("FAIL hmaster_lag: got %0d want 1", hmaster); end
        tick();
        n_cmp++; if (hmaster !== 2'd2) begin n_bad++; $display("FAIL hmaster_follow: got %0d want 2", hmaster); end
    endtask

    task automatic test_round_robin();
        int ord[4] = '{1, 2, 3, 1};
        do_reset();
        hbusreq1 = 1'b1; hbusreq2 = 1'b1; hbusreq3 = 1'b1;
        for (int i = 0; i < 4; i++) begin
            set_trans(mg, 2'b10);
            tick();
            n_cmp++;
            if (gvec() !== mvec(ord[i])) begin
                n_bad++; $display("FAIL rr_order[%0d]: got %b want %b", i, gvec(), mvec(ord[i]));
            end
            htrans1 = 2'b00; htrans2 = 2'b00; htrans3 = 2'b00;
            tick();
        end
    endtask

    task automatic test_hold_limit();
        logic [2:0] want;
        do_reset();
        hbusreq1 = 1'b1; hbusreq2 = 1'b1;
        for (int cyc = 1; cyc <= 5; cyc++) begin
            htrans1 = (cyc % 2 == 1) ? 2'b10 : 2'b11;
            tick();
            want = (cyc < 5) ? 3'b001 : 3'b010;
            n_cmp++;
            if (gvec() !== want) begin
                n_bad++; $display("FAIL hold_cyc%0d: got %b want %b", cyc, gvec(), want);
            end
        end
    endtask

    task automatic test_lock();
        do_reset();
        hbusreq1 = 1'b1; hlock1 = 1'b1; hbusreq2 = 1'b1;
        for (int cyc = 0; cyc < 8; cyc++) begin
            htrans1 = (cyc % 2 == 0) ? 2'b10 : 2'b11;
            tick();
        end
        n_cmp++; if (gvec() !== 3'b001) begin n_bad++; $display("FAIL lock_hold: got %b want %b", gvec(), 3'b001); end
        n_cmp++; if (hmastlock !== 1'b1) begin n_bad++; $display("FAIL lock_hmastlock: got %0d want 1", hmastlock); end
        hlock1 = 1'b0; htrans1 = 2'b00;
        tick();
        n_cmp++; if (gvec() !== 3'b010) begin n_bad++; $display("FAIL unlock_grant: got %b want %b", gvec(), 3'b010); end
        tick();
        n_cmp++; if (hmastlock !== 1'b0) begin n_bad++; $display("FAIL unlock_hmastlock: got %0d want 0", hmastlock); end
    endtask

    task automatic test_split();
        do_reset();
        hbusreq2 = 1'b1;
        tick();
        htrans2 = 2'b10; tick();
        htrans2 = 2'b11; tick();
        n_cmp++; if (hmaster_d !== 2'd2) begin n_bad++; $display("FAIL split_setup: got %0d want 2", hmaster_d); end
        hresp = 2'b11; hready = 1'b0;
        tick();
        n_cmp++; if (gvec() !== 3'b001) begin n_bad++; $display("FAIL split_force: got %b want %b", gvec(), 3'b001); end
        hready = 1'b1; tick();
        hresp = 2'b00; htrans2 = 2'b10;
        repeat (3) tick();
        n_cmp++; if (gvec() !== 3'b001) begin n_bad++; $display("FAIL split_parked: got %b want %b", gvec(), 3'b001); end
        hsplit3 = 16'h0004; tick();
        n_cmp++; if (gvec() !== 3'b001) begin n_bad++; $display("FAIL release_delay: got %b want %b", gvec(), 3'b001); end
        hsplit3 = 16'h0000; tick();
        n_cmp++; if (gvec() !== 3'b010) begin n_bad++; $display("FAIL release_grant: got %b want %b", gvec(), 3'b010); end
        tick(); tick();
        hresp = 2'b11; hready = 1'b0; hsplit1 = 16'h0004;
        tick();
        hsplit1 = 16'h0000; hready = 1'b1; tick();
        hresp = 2'b00;
        tick(); tick();
        n_cmp++; if (gvec() !== 3'b001) begin n_bad++; $display("FAIL set_beats_release: got %b want %b", gvec(), 3'b001); end
    endtask

    task automatic test_retry_reset();
        do_reset();
        hbusreq1 = 1'b1; hlock1 = 1'b1; htrans1 = 2'b10; hbusreq3 = 1'b1;
        tick(); tick();
        n_cmp++; if (hmaster_d !== 2'd1) begin n_bad++; $display("FAIL retry_setup: got %0d want 1", hmaster_d); end
        hresp = 2'b10; hready = 1'b0;
        tick();
        n_cmp++; if (gvec() !== 3'b100) begin n_bad++; $display("FAIL retry_grant: got %b want %b", gvec(), 3'b100); end
        hready = 1'b1; htrans3 = 2'b10; tick();
        hresp = 2'b00; htrans3 = 2'b11;
        tick(); tick();
        n_cmp++; if (gvec() !== 3'b100) begin n_bad++; $display("FAIL retry_burst: got %b want %b", gvec(), 3'b100); end
        hreset = 1'b1; tick(); hreset = 1'b0;
        n_cmp++; if (gvec() !== 3'b001) begin n_bad++; $display("FAIL midreset_grant: got %b want %b", gvec(), 3'b001); end
        n_cmp++; if (hmaster !== 2'd1) begin n_bad++; $display("FAIL midreset_hmaster: got %0d want 1", hmaster); end
        n_cmp++; if (hmaster_d !== 2'd0) begin n_bad++; $display("FAIL midreset_hmaster_d: got %0d want 0", hmaster_d); end
        n_cmp++; if (hmastlock !== 1'b0) begin n_bad++; $display("FAIL midreset_hmastlock: got %0d want 0", hmastlock); end
    endtask

    task automatic test_random();
        int pend;
        pend = 0;
        do_reset();
        for (int cyc = 0; cyc < 1500; cyc++) begin
            hreset   = ($urandom_range(0, 99) == 0);
            hbusreq1 = 1'($urandom_range(0, 1));
            hbusreq2 = 1'($urandom_range(0, 1));
            hbusreq3 = 1'($urandom_range(0, 1));
            hlock1   = ($urandom_range(0, 5) == 0);
            hlock2   = ($urandom_range(0, 5) == 0);
            hlock3   = ($urandom_range(0, 5) == 0);
            htrans1  = 2'($urandom_range(0, 3));
            htrans2  = 2'($urandom_range(0, 3));
            htrans3  = 2'($urandom_range(0, 3));
            hsplit1  = ($urandom_range(0, 7) == 0) ? 16'($urandom) : 16'h0;
            hsplit2  = ($urandom_range(0, 15) == 0) ? 16'($urandom) : 16'h0;
            hsplit3  = ($urandom_range(0, 15) == 0) ? 16'($urandom) : 16'h0;
            hsplit4  = ($urandom_range(0, 15) == 0) ? 16'($urandom) : 16'h0;
            if (pend != 0) begin
                hready = 1'b1; pend = 0;
            end else if ($urandom_range(0, 9) == 0) begin
                hresp = 2'($urandom_range(1, 3)); hready = 1'b0; pend = 1;
            end else begin
                hresp = 2'b00; hready = ($urandom_range(0, 3) != 0);
            end
            tick();
            n_cmp++;
            if (gvec() !== mvec(mg) || hmaster !== 2'(mh) || hmaster_d !== 2'(mhd) || hmastlock !== 1'(mml)) begin
                n_bad++;
                $display("FAIL random_cyc%0d: got g=%b hm=%0d hmd=%0d lk=%0d want g=%b hm=%0d hmd=%0d lk=%0d",
                         cyc, gvec(), hmaster, hmaster_d, hmastlock, mvec(mg), mh, mhd, mml);
            end
        end
        hreset = 1'b0;
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1);
    end

    initial begin
        quiet();
        test_reset();
        test_round_robin();
        test_hold_limit();
        test_lock();
        test_split();
        test_retry_reset();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
